// File: rtl/ibex_alu_arbiter.sv
// ibex_alu_arbiter: shares one combinational ibex_alu between NUM_REQ requesters.
// Round-robin arbitration latches the winner's operator/operands and drives them to
// the ALU. The ALU result is registered and returned on a valid/ready response
// channel that carries the requester id.
// Optional feature macro: IBEX_ALU_ARB_B2B_EN. When it is defined, a new request
// can be arbitrated in the same cycle as the response handshake.
module ibex_alu_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*7-1:0]  req_operator_i,
  input  logic [NUM_REQ*32-1:0] req_operand_a_i,
  input  logic [NUM_REQ*32-1:0] req_operand_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [31:0]           resp_result_o,
  output logic                  resp_cmp_o,
  output logic [6:0]            alu_operator_o,
  output logic [31:0]           alu_operand_a_o,
  output logic [31:0]           alu_operand_b_o,
  input  logic [31:0]           alu_result_i,
  input  logic                  alu_cmp_result_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state;
  state_e           state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [6:0]       op_q;
  logic [31:0]      operand_a_q;
  logic [31:0]      operand_b_q;
  logic [ID_W-1:0]  id_q;
  logic [31:0]      result_q;
  logic             cmp_q;

  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  ptr_next;
  logic             found;
  logic             arb_en;
  logic             grant;
  logic [6:0]       win_op;
  logic [31:0]      win_a;
  logic [31:0]      win_b;

  // Arbitration is allowed in IDLE and, with back-to-back enabled, during the
  // response handshake. It is never allowed while reset is asserted.
`ifdef IBEX_ALU_ARB_B2B_EN
  assign arb_en = !rst_i && ((state == IDLE) || ((state == RESP) && resp_ready_i));
`else
  assign arb_en = !rst_i && (state == IDLE);
`endif

  assign grant = arb_en && found;

  // Round-robin search: the first valid request at or after rr_ptr (wrapping) wins.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end else begin
        found  = found;
      end
    end
    ptr_next = ID_W'((int'(winner) + 1) % NUM_REQ);
    win_op   = req_operator_i[int'(winner)*7 +: 7];
    win_a    = req_operand_a_i[int'(winner)*32 +: 32];
    win_b    = req_operand_b_i[int'(winner)*32 +: 32];
  end

  // Only the granted requester sees ready; the grant is one-hot or zero.
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant) state_next = EXEC;
        else       state_next = IDLE;
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (!resp_ready_i) state_next = RESP;
        else if (grant)    state_next = EXEC;
        else               state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, request payload latch, and ALU result capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      op_q        <= 7'd0;
      operand_a_q <= 32'd0;
      operand_b_q <= 32'd0;
      id_q        <= '0;
      result_q    <= 32'd0;
      cmp_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        op_q        <= win_op;
        operand_a_q <= win_a;
        operand_b_q <= win_b;
        id_q        <= winner;
        rr_ptr      <= ptr_next;
      end
      if (state == EXEC) begin
        result_q <= alu_result_i;
        cmp_q    <= alu_cmp_result_i;
      end
    end
  end

  // The ALU is always driven from the latched registers, in every state.
  assign alu_operator_o  = op_q;
  assign alu_operand_a_o = operand_a_q;
  assign alu_operand_b_o = operand_b_q;

  assign resp_valid_o  = (state == RESP);
  assign resp_id_o     = id_q;
  assign resp_result_o = result_q;
  assign resp_cmp_o    = cmp_q;

endmodule

// File: doc/ibex_alu_arbiter.md
Name: ibex_alu_arbiter

Overview:
Shares one combinational ibex_alu between NUM_REQ requesters, such as a debug/self-test engine and an accelerator sequencer. Requests are arbitrated round-robin. The winner's operator and operands are latched and driven to the ALU, the result is registered, and it is returned on a valid/ready response channel tagged with the requester id. The block sits between the requesters and the ALU's operator_i/operand_a_i/operand_b_i inputs and its result_o/comparison_result_o outputs. It keeps instr_first_cycle_i and multdiv_sel_i tied 0 at the ALU.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), width of the requester id (derived, not overridable)

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NUM_REQ  request valid, one bit per requester
req_ready_o  out  NUM_REQ  request accepted (one-hot or zero)
req_operator_i  in  NUM_REQ*7  per-requester ibex_pkg::alu_op_e, requester k at [7k+6:7k]
req_operand_a_i  in  NUM_REQ*32  per-requester operand A
req_operand_b_i  in  NUM_REQ*32  per-requester operand B
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response consumed
resp_id_o  out  ID_W  index of the requester that owns the response
resp_result_o  out  32  captured alu result_o
resp_cmp_o  out  1  captured alu comparison_result_o
alu_operator_o  out  7  to ALU operator_i
alu_operand_a_o  out  32  to ALU operand_a_i
alu_operand_b_o  out  32  to ALU operand_b_i
alu_result_i  in  32  from ALU result_o
alu_cmp_result_i  in  1  from ALU comparison_result_o

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE, rr_ptr=0, op/operand/id/result registers=0.
  - All outputs 0: req_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_result_o=0, resp_cmp_o=0, alu_*_o=0 (operator 0 = ALU_ADD).
- Reset mid-operation: the in-flight op is discarded with no response. The cycle after reset deasserts, state is IDLE.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: winner = first asserted req_valid_i scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
    - req_ready_o[winner]=1 combinationally; all other ready bits are 0.
    - On that posedge: latch the winner's operator/operands and its id; rr_ptr=(winner+1) mod NUM_REQ; go to EXEC.
    - With no valid request, stay in IDLE and keep req_ready_o=0.
  - EXEC: alu_*_o are driven from the latched registers (they are always driven from them, in every state).
    - On the posedge, capture alu_result_i and alu_cmp_result_i, then go to RESP.
    - req_ready_o=0.
  - RESP: resp_valid_o=1; resp_id_o, resp_result_o and resp_cmp_o are held stable.
    - When resp_ready_i=1, the handshake completes and the block goes to IDLE; otherwise it stays in RESP indefinitely.
    - req_ready_o=0 (subject to the optional feature below).
- Latency: accept at edge T, then resp_valid_o=1 in the cycle after edge T+1. Throughput is 1 op per 3 cycles when resp_ready_i is held at 1.
- Requesters hold valid and payload stable until ready is seen. Dropping valid before acceptance is legal and the request is simply not served.
- A requester's req_valid_i arriving while its own response is pending is legal; it is arbitrated on the next IDLE.
- Single requester (NUM_REQ=1): rr_ptr is a constant 0 and the id is always 0.
- Operators are not interpreted; any 7-bit value is passed through unchanged.

Optional Feature:
IBEX_ALU_ARB_B2B_EN
- Defined: in RESP, when resp_ready_i=1, arbitration also runs in the same cycle (same rules as IDLE).
  - If a request wins, its ready is asserted, the payload is latched and the state goes directly to EXEC. Throughput is 1 op per 2 cycles.
  - If no request is valid, the state goes to IDLE.
- Undefined: behaviour is exactly as described above; RESP always returns to IDLE.

Test Plan:
- Single op: req0 ALU_ADD, a=32, b=64, resp_ready=1 -> req_ready_o[0] in the accept cycle; 2 cycles later resp_valid=1, result=96, id=0.
- Round-robin: both requesters valid continuously (req0 ALU_SUB 512,256; req1 ALU_XOR FFFFFF00,00FFFFFF) -> grant order 0,1,0,1; results 0x100, 0xFF0000FF alternating; no requester granted twice in a row.
- Backpressure: req0 ALU_AND FFFFFF00,00FFFFFF, resp_ready=0 for 5 cycles -> resp_valid held with result 0x00FFFF00; req_ready_o stays 0 for req1; response completes on the first cycle resp_ready=1.
- Comparison: req1 ALU_LT a=32 b=64 -> resp_cmp=1, id=1; ALU_EQ 32,32 -> resp_cmp=1; ALU_NE 32,32 -> resp_cmp=0.
- Reset in EXEC: accept ALU_ADD, then assert rst_i for 1 cycle -> resp_valid never rises, all outputs 0, rr_ptr=0; the next request from requester 0 is granted first.
- IBEX_ALU_ARB_B2B_EN: req0 valid continuously, resp_ready=1 -> accepts at 2-cycle spacing and req_ready_o[0] coincides with the resp handshake. With the macro undefined -> 3-cycle spacing.
